tron_dir_input: RTL and testbench



---
 rtl/tron_pkg.sv | 47 ++++
 rtl/dir_queue.sv | 87 ++++++++
 rtl/tron_dir_input.sv | 75 +++++++
 tb/tb_tron_dir_input.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/tron_pkg.sv
// tron_pkg: shared definitions for the Tron steering input path.
//   dir_t                   2-bit direction (00 down, 01 up, 10 left, 11 right)
//   DIR_*                   direction constants
//   KEY_P0_* / KEY_P1_*     make codes for the two key maps (arrows / WASD)
//   decode_p0 / decode_p1   scan code -> {hit, dir}
package tron_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_DOWN  = 2'b00;
  localparam dir_t DIR_UP    = 2'b01;
  localparam dir_t DIR_LEFT  = 2'b10;
  localparam dir_t DIR_RIGHT = 2'b11;

  localparam logic [7:0] KEY_P0_UP    = 8'h75;
  localparam logic [7:0] KEY_P0_DOWN  = 8'h72;
  localparam logic [7:0] KEY_P0_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_P0_RIGHT = 8'h74;

  localparam logic [7:0] KEY_P1_UP    = 8'h1D;
  localparam logic [7:0] KEY_P1_DOWN  = 8'h1B;
  localparam logic [7:0] KEY_P1_LEFT  = 8'h1C;
  localparam logic [7:0] KEY_P1_RIGHT = 8'h23;

  // Returns {hit, dir}; hit=0 for codes outside the arrow-key map.
  function automatic logic [2:0] decode_p0(input logic [7:0] code);
    case (code)
      KEY_P0_UP:    return {1'b1, DIR_UP};
      KEY_P0_DOWN:  return {1'b1, DIR_DOWN};
      KEY_P0_LEFT:  return {1'b1, DIR_LEFT};
      KEY_P0_RIGHT: return {1'b1, DIR_RIGHT};
      default:      return 3'b000;
    endcase
  endfunction

  // Returns {hit, dir}; hit=0 for codes outside the WASD map.
  function automatic logic [2:0] decode_p1(input logic [7:0] code);
    case (code)
      KEY_P1_UP:    return {1'b1, DIR_UP};
      KEY_P1_DOWN:  return {1'b1, DIR_DOWN};
      KEY_P1_LEFT:  return {1'b1, DIR_LEFT};
      KEY_P1_RIGHT: return {1'b1, DIR_RIGHT};
      default:      return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/dir_queue.sv
// dir_queue: per-player turn queue and committed direction.
//   clk, reset     clock, synchronous active-high reset
//   push, push_dir candidate turn (filtered here by the acceptance rule)
//   pop            movement step: commit head entry if the queue is non-empty
//   dir            committed direction (INIT after reset)
//   pending        queue non-empty
//   ovf            sticky: an accepted turn was dropped on a full queue
module dir_queue
  import tron_pkg::*;
#(
  parameter int         DEPTH = 4,
  parameter logic [1:0] INIT  = 2'b11
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  dir_t push_dir,
  input  logic pop,
  output dir_t dir,
  output logic pending,
  output logic ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  dir_t          fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] tail_ptr;
  logic [CW-1:0] count;
  dir_t          dir_q;
  logic          ovf_q;

  dir_t ref_dir;
  logic not_empty;
  logic full;
  logic accept;
  logic do_push;
  logic do_pop;

  assign not_empty = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign tail_ptr  = wr_ptr - PW'(1);

  // New turns are judged against the last queued turn, so a burst of keys
  // within one frame is filtered as if each had already been applied.
  assign ref_dir = not_empty ? fifo_mem[tail_ptr] : dir_q;

  // Differing axis bit rejects both reversals and repeats.
  assign accept  = push && (push_dir[1] != ref_dir[1]);
  assign do_pop  = pop && not_empty;
  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign do_push = accept && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dir_q  <= INIT;
      ovf_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        dir_q  <= fifo_mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (accept && !do_push) ovf_q <= 1'b1;
    end
  end

  // Storage needs no reset: entries are only read below the occupancy count.
  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr] <= push_dir;
  end

  assign dir     = dir_q;
  assign pending = not_empty;
  assign ovf     = ovf_q;

endmodule

// File: rtl/tron_dir_input.sv
// tron_dir_input: keyboard make codes -> per-player queued steering commands.
//   clk, reset            clock, synchronous active-high reset
//   valid                 one-cycle strobe qualifying makeBreak/outCode; there
//                         is no ready: every strobed event is consumed in the
//                         cycle it is presented (no back-pressure)
//   makeBreak, outCode    1 = press; scan code (prefixes stripped)
//   p0_update, p1_update  movement-step strobes, each pops one queued turn
//   p0_dir, p1_dir        committed directions
//   p0_pending, p1_pending, p0_ovf, p1_ovf  queue status
// Build option: TRON_P2_EN enables the WASD player; otherwise player-1
// outputs are constant (P1_INIT, 0, 0).
module tron_dir_input
  import tron_pkg::*;
#(
  parameter int         DEPTH   = 4,
  parameter logic [1:0] P0_INIT = 2'b11,
  parameter logic [1:0] P1_INIT = 2'b10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic       makeBreak,
  input  logic [7:0] outCode,
  input  logic       p0_update,
  input  logic       p1_update,
  output logic [1:0] p0_dir,
  output logic [1:0] p1_dir,
  output logic       p0_pending,
  output logic       p1_pending,
  output logic       p0_ovf,
  output logic       p1_ovf
);

  logic       press;
  logic [2:0] p0_key;

  assign press  = valid && makeBreak;
  assign p0_key = decode_p0(outCode);

  dir_queue #(.DEPTH(DEPTH), .INIT(P0_INIT)) u_p0_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (press && p0_key[2]),
    .push_dir (p0_key[1:0]),
    .pop      (p0_update),
    .dir      (p0_dir),
    .pending  (p0_pending),
    .ovf      (p0_ovf)
  );

`ifdef TRON_P2_EN
  logic [2:0] p1_key;

  assign p1_key = decode_p1(outCode);

  dir_queue #(.DEPTH(DEPTH), .INIT(P1_INIT)) u_p1_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (press && p1_key[2]),
    .push_dir (p1_key[1:0]),
    .pop      (p1_update),
    .dir      (p1_dir),
    .pending  (p1_pending),
    .ovf      (p1_ovf)
  );
`else
  logic unused_p1_update;

  assign unused_p1_update = p1_update;
  assign p1_dir           = P1_INIT;
  assign p1_pending       = 1'b0;
  assign p1_ovf           = 1'b0;
`endif

endmodule

// File: tb/tb_tron_dir_input.sv
// tb_tron_dir_input: directed vector table plus hand-written sequences for
// reset-during-operation, queue overflow and full-queue push+pop.
module tb_tron_dir_input;

`ifdef TRON_P2_EN
  localparam bit P2 = 1'b1;
`else
  localparam bit P2 = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       valid;
  logic       makeBreak;
  logic [7:0] outCode;
  logic       p0_update;
  logic       p1_update;
  logic [1:0] p0_dir;
  logic [1:0] p1_dir;
  logic       p0_pending;
  logic       p1_pending;
  logic       p0_ovf;
  logic       p1_ovf;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_q[$];

  tron_dir_input dut (
    .clk        (clk),
    .reset      (reset),
    .valid      (valid),
    .makeBreak  (makeBreak),
    .outCode    (outCode),
    .p0_update  (p0_update),
    .p1_update  (p1_update),
    .p0_dir     (p0_dir),
    .p1_dir     (p1_dir),
    .p0_pending (p0_pending),
    .p1_pending (p1_pending),
    .p0_ovf     (p0_ovf),
    .p1_ovf     (p1_ovf)
  );

  // ---------------- clock / reset ----------------
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  // One cycle of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic drive(input logic v, input logic mb, input logic [7:0] code,
                       input logic u0, input logic u1);
    valid     = v;
    makeBreak = mb;
    outCode   = code;
    p0_update = u0;
    p1_update = u1;
    tick();
    valid     = 1'b0;
    makeBreak = 1'b0;
    outCode   = 8'h00;
    p0_update = 1'b0;
    p1_update = 1'b0;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag,
                           input logic [1:0] e0d, input logic e0p, input logic e0o,
                           input logic [1:0] e1d, input logic e1p, input logic e1o);
    check({tag, " p0_dir"},     {6'd0, p0_dir},     {6'd0, e0d});
    check({tag, " p0_pending"}, {7'd0, p0_pending}, {7'd0, e0p});
    check({tag, " p0_ovf"},     {7'd0, p0_ovf},     {7'd0, e0o});
    check({tag, " p1_dir"},     {6'd0, p1_dir},     {6'd0, e1d});
    check({tag, " p1_pending"}, {7'd0, p1_pending}, {7'd0, e1p});
    check({tag, " p1_ovf"},     {7'd0, p1_ovf},     {7'd0, e1o});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       v;
    logic       mb;
    logic [7:0] code;
    logic       u0;
    logic       u1;
    logic [1:0] p0d;
    logic       p0p;
    logic       p0o;
    logic [1:0] p1d;
    logic       p1p;
    logic       p1o;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  initial begin
    reset     = 1'b1;
    valid     = 1'b0;
    makeBreak = 1'b0;
    outCode   = 8'h00;
    p0_update = 1'b0;
    p1_update = 1'b0;

    //          v     mb    code   u0    u1    p0d    p0p   p0o   p1d                     p1p   p1o
    vecs[0]  = '{1'b1, 1'b1, 8'h6B, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 2'b10,                  1'b0, 1'b0}; // reversal dropped
    vecs[1]  = '{1'b1, 1'b1, 8'h74, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 2'b10,                  1'b0, 1'b0}; // repeat dropped
    vecs[2]  = '{1'b1, 1'b0, 8'h75, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 2'b10,                  1'b0, 1'b0}; // break ignored
    vecs[3]  = '{1'b0, 1'b1, 8'h75, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 2'b10,                  1'b0, 1'b0}; // no valid
    vecs[4]  = '{1'b1, 1'b1, 8'h75, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 2'b10,                  1'b0, 1'b0}; // up queued
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 2'b10,                  1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 2'b10,                  1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 2'b10,                  1'b0, 1'b0}; // commit up
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 2'b10,                  1'b0, 1'b0}; // empty pop
    vecs[9]  = '{1'b1, 1'b1, 8'h1D, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b10,                  P2,   1'b0}; // W
    vecs[10] = '{1'b1, 1'b1, 8'h72, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b10,                  P2,   1'b0}; // down vs up
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, P2 ? 2'b01 : 2'b10,     1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 8'h1C, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, P2 ? 2'b01 : 2'b10,     P2,   1'b0}; // A
    vecs[13] = '{1'b1, 1'b1, 8'h1D, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, P2 ? 2'b01 : 2'b10,     P2,   1'b0}; // W vs tail left
    vecs[14] = '{1'b1, 1'b1, 8'h29, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, P2 ? 2'b01 : 2'b10,     P2,   1'b0}; // unmapped
    vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 2'b10,                  P2,   1'b0};
    vecs[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, P2 ? 2'b01 : 2'b10,     1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 8'h6B, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, P2 ? 2'b01 : 2'b10,     1'b0, 1'b0}; // push+pop on empty
    vecs[18] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, P2 ? 2'b01 : 2'b10,     1'b0, 1'b0};

    // Reset state
    do_reset();
    check_all("reset", 2'b11, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].v, vecs[i].mb, vecs[i].code, vecs[i].u0, vecs[i].u1);
      check_all($sformatf("vec%0d", i), vecs[i].p0d, vecs[i].p0p, vecs[i].p0o,
                vecs[i].p1d, vecs[i].p1p, vecs[i].p1o);
    end

    // Reset while a turn is queued, with an update in the reset cycle.
    drive(1'b1, 1'b1, 8'h72, 1'b0, 1'b0);     // down vs 10 -> queued
    check("pre_reset p0_pending", {7'd0, p0_pending}, 8'd1);
    reset     = 1'b1;
    p0_update = 1'b1;
    tick();
    reset     = 1'b0;
    p0_update = 1'b0;
    check("mid_reset p0_dir",     {6'd0, p0_dir},     8'h03);
    check("mid_reset p0_pending", {7'd0, p0_pending}, 8'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);     // queue really discarded
    check("post_reset p0_dir",    {6'd0, p0_dir},     8'h03);

    // Fill the queue: up, left, down, right all accepted.
    exp_q.delete();
    drive(1'b1, 1'b1, 8'h75, 1'b0, 1'b0); exp_q.push_back(2'b01);
    drive(1'b1, 1'b1, 8'h6B, 1'b0, 1'b0); exp_q.push_back(2'b10);
    drive(1'b1, 1'b1, 8'h72, 1'b0, 1'b0); exp_q.push_back(2'b00);
    drive(1'b1, 1'b1, 8'h74, 1'b0, 1'b0); exp_q.push_back(2'b11);
    check("fill p0_ovf",     {7'd0, p0_ovf},     8'd0);
    check("fill p0_pending", {7'd0, p0_pending}, 8'd1);
    check("fill p0_dir",     {6'd0, p0_dir},     8'h03);

    // Full queue: push up (vs tail right) together with a pop.
    drive(1'b1, 1'b1, 8'h75, 1'b1, 1'b0);
    check("full_pp p0_dir", {6'd0, p0_dir}, {6'd0, exp_q.pop_front()});
    exp_q.push_back(2'b01);
    check("full_pp p0_ovf",     {7'd0, p0_ovf},     8'd0);
    check("full_pp p0_pending", {7'd0, p0_pending}, 8'd1);

    // Still four entries: left (vs tail up) is accepted but has no room.
    drive(1'b1, 1'b1, 8'h6B, 1'b0, 1'b0);
    check("overflow p0_ovf", {7'd0, p0_ovf}, 8'd1);
    // Up vs tail up is rejected outright.
    drive(1'b1, 1'b1, 8'h75, 1'b0, 1'b0);
    check("overflow2 p0_ovf", {7'd0, p0_ovf}, 8'd1);
    check("overflow p1_dir",  {6'd0, p1_dir}, 8'h02);

    // Drain: 10, 00, 11, 01 in order, pending drops with the last pop.
    for (int i = 0; i < 4; i++) begin
      logic [1:0] e;
      e = exp_q.pop_front();
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      check($sformatf("drain%0d p0_dir", i), {6'd0, p0_dir}, {6'd0, e});
      check($sformatf("drain%0d p0_pending", i), {7'd0, p0_pending},
            {7'd0, (exp_q.size() != 0)});
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("drained p0_dir", {6'd0, p0_dir}, 8'h01);
    check("drained p0_ovf", {7'd0, p0_ovf}, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
